// File: rtl/lieat_idu_disp_q_pkg.sv
// Shared constants for the dispatch queue: channel indices, default sizes and pointer helpers.
package lieat_idu_disp_q_pkg;

  localparam int unsigned DISP_COM    = 0;
  localparam int unsigned DISP_LSU    = 1;
  localparam int unsigned DISP_MULDIV = 2;
  localparam int unsigned DISP_VPU    = 3;
  localparam int unsigned DISP_FPU    = 4;

  localparam int unsigned DISP_NCH   = 5;
  localparam int unsigned DISP_DEPTH = 2;
  localparam int unsigned DISP_PW    = 64;

  // Pointer width that still works for DEPTH==1.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Increment that wraps depth-1 -> 0 for non-power-of-2 depths.
  function automatic int unsigned ptr_wrap_inc(int unsigned ptr, int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/lieat_idu_disp_q_if.sv
// Decode-side and dispatch-side signals of the dispatch queue.
interface lieat_idu_disp_q_if #(
  parameter int unsigned NCH   = 5,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PW    = 64
) ();
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic           flush_req;
  logic           id_i_valid;
  logic           id_i_ready;
  logic [NCH-1:0] id_i_op;
  logic [PW-1:0]  id_i_payload;
  logic           disp_condition;
  logic [NCH-1:0] disp_valid;
  logic [NCH-1:0] disp_ready;
  logic [PW-1:0]  disp_payload;
  logic [NCH-1:0] disp_op;
  logic           disp_valid_pre;
  logic           disp_ena;
  logic [CW-1:0]  disp_count;

  modport master (
    output flush_req, id_i_valid, id_i_op, id_i_payload, disp_condition, disp_ready,
    input  id_i_ready, disp_valid, disp_payload, disp_op, disp_valid_pre, disp_ena, disp_count
  );

  modport slave (
    input  flush_req, id_i_valid, id_i_op, id_i_payload, disp_condition, disp_ready,
    output id_i_ready, disp_valid, disp_payload, disp_op, disp_valid_pre, disp_ena, disp_count
  );
endinterface

// File: rtl/lieat_disp_fifo.sv
// DEPTH-entry storage of {op, payload} with wrapping pointers and occupancy count.
module lieat_disp_fifo
  import lieat_idu_disp_q_pkg::*;
#(
  parameter int unsigned NCH   = DISP_NCH,
  parameter int unsigned DEPTH = DISP_DEPTH,
  parameter int unsigned PW    = DISP_PW,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  input  logic           enq_i,
  input  logic           deq_i,
  input  logic [NCH-1:0] wop_i,
  input  logic [PW-1:0]  wpay_i,
  output logic [NCH-1:0] rop_o,
  output logic [PW-1:0]  rpay_o,
  output logic [CW-1:0]  count_o
);
  localparam int unsigned PTRW = ptr_width(DEPTH);
  localparam int unsigned EW   = NCH + PW;

  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_ld, rd_ld, count_ld, wr_en;
  logic [EW-1:0]   mem_q [DEPTH];

  always_comb begin
    wr_en    = enq_i & ~flush_i;
    wr_ld    = flush_i | enq_i;
    rd_ld    = flush_i | deq_i;
    count_ld = flush_i | enq_i | deq_i;
    wr_ptr_d = flush_i ? '0 : PTRW'(ptr_wrap_inc(32'(wr_ptr_q), DEPTH));
    rd_ptr_d = flush_i ? '0 : PTRW'(ptr_wrap_inc(32'(rd_ptr_q), DEPTH));
    count_d  = flush_i ? '0 : count_q + CW'(enq_i) - CW'(deq_i);
  end

  lieat_general_dfflr #(.DW(PTRW)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .ld_i(wr_ld), .d_i(wr_ptr_d), .q_o(wr_ptr_q)
  );
  lieat_general_dfflr #(.DW(PTRW)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .ld_i(rd_ld), .d_i(rd_ptr_d), .q_o(rd_ptr_q)
  );
  lieat_general_dfflr #(.DW(CW)) u_count (
    .clk(clk), .rst_n(rst_n), .ld_i(count_ld), .d_i(count_d), .q_o(count_q)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    lieat_general_dffl #(.DW(EW)) u_ent (
      .clk(clk),
      .ld_i(wr_en & (wr_ptr_q == PTRW'(i))),
      .d_i({wop_i, wpay_i}),
      .q_o(mem_q[i])
    );
  end

  assign {rop_o, rpay_o} = mem_q[rd_ptr_q];
  assign count_o         = count_q;
endmodule

// File: rtl/lieat_general_dffl.sv
// Load-enabled flop without reset, used for payload storage.
module lieat_general_dffl #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          ld_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] q_q;

  always_ff @(posedge clk) begin
    if (ld_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/lieat_general_dfflr.sv
// Load-enabled flop with synchronous active-low reset to zero.
module lieat_general_dfflr #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst_n)    q_q <= '0;
    else if (ld_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/lieat_idu_disp_q.sv
// Dispatch queue: FIFO of decoded ops whose head is offered to every targeted channel;
// the head retires once all of its target channels have handshaken.
module lieat_idu_disp_q
  import lieat_idu_disp_q_pkg::*;
#(
  parameter int unsigned NCH   = DISP_NCH,
  parameter int unsigned DEPTH = DISP_DEPTH,
  parameter int unsigned PW    = DISP_PW
) (
  input  logic               clock,
  input  logic               reset,
  lieat_idu_disp_q_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [NCH-1:0] head_op, done_q, done_d, hs, valid_c;
  logic [PW-1:0]  head_pay;
  logic [CW-1:0]  count;
  logic           pre, hv, ena, rdy, enq, done_ld;

  // Head gating, per-channel handshake tracking and retire decision.
  always_comb begin
    pre     = (count != '0);
    hv      = pre & bus.disp_condition & ~bus.flush_req;
    valid_c = {NCH{hv}} & head_op & ~done_q;
    hs      = valid_c & bus.disp_ready;
    ena     = hv & ((head_op & ~(done_q | hs)) == '0);
    rdy     = (count < CW'(DEPTH)) | ena;
    enq     = bus.id_i_valid & rdy & ~bus.flush_req;
    done_ld = bus.flush_req | ena | (|hs);
    done_d  = (bus.flush_req | ena) ? '0 : (done_q | hs);
  end

  lieat_general_dfflr #(.DW(NCH)) u_done (
    .clk(clock), .rst_n(reset), .ld_i(done_ld), .d_i(done_d), .q_o(done_q)
  );

  lieat_disp_fifo #(.NCH(NCH), .DEPTH(DEPTH), .PW(PW)) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .flush_i (bus.flush_req),
    .enq_i   (enq),
    .deq_i   (ena),
    .wop_i   (bus.id_i_op),
    .wpay_i  (bus.id_i_payload),
    .rop_o   (head_op),
    .rpay_o  (head_pay),
    .count_o (count)
  );

  assign bus.id_i_ready     = rdy;
  assign bus.disp_valid     = valid_c;
  assign bus.disp_payload   = head_pay;
  assign bus.disp_op        = head_op;
  assign bus.disp_valid_pre = pre;
  assign bus.disp_ena       = ena;
  assign bus.disp_count     = count;
endmodule
